// File: rtl/imm_gen_pipe.sv
// Registered RV32I immediate generator with a 1- or 2-deep output pipeline.
// Optional macro IMM_GEN_ZIMM_EN: decode CSR*I zimm (fmt 6) on the SYSTEM opcode.
module imm_gen_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_fmt,
    output logic            imm_valid,
    output logic            imm_illegal
);

    localparam int unsigned FMT_W = 3;

    localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [FMT_W-1:0] FMT_Z    = 3'd6;
`endif
    localparam logic [FMT_W-1:0] FMT_ILL  = 3'd7;

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [FMT_W-1:0] fmt;
        logic [XLEN-1:0]  imm;
    } stage_t;

    logic [6:0]       opcode;
    logic [31:0]      dec_imm32;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_illegal;
    stage_t           s1;
    stage_t           s_out;

    assign opcode = instr[6:0];

    // Decode the 32-bit immediate; widening to XLEN happens at capture.
    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                dec_fmt   = FMT_I;
            end
            7'b0100011: begin
                dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt   = FMT_S;
            end
            7'b1100011: begin
                dec_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
                dec_fmt   = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {instr[31:12], 12'b0};
                dec_fmt   = FMT_U;
            end
            7'b1101111: begin
                dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                dec_fmt   = FMT_J;
            end
            7'b0110011: begin
                dec_fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
                if (instr[14:12] == 3'b101 || instr[14:12] == 3'b110 ||
                    instr[14:12] == 3'b111) begin
                    dec_imm32 = {27'b0, instr[19:15]};
                    dec_fmt   = FMT_Z;
                end else begin
                    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt   = FMT_I;
                end
`else
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                dec_fmt   = FMT_I;
`endif
            end
            default: begin
                dec_fmt     = FMT_ILL;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Stage 1: capture on load; flush wins over load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else if (flush) begin
            s1 <= '0;
        end else if (load) begin
            s1.valid   <= 1'b1;
            s1.illegal <= dec_illegal;
            s1.fmt     <= dec_fmt;
            s1.imm     <= XLEN'($signed(dec_imm32));
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_two
            stage_t s2;

            // Stage 2 tracks stage 1 every cycle so valid never drops between loads.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2 <= '0;
                end else if (flush) begin
                    s2 <= '0;
                end else begin
                    s2 <= s1;
                end
            end

            assign s_out = s2;
        end else begin : g_one
            assign s_out = s1;
        end
    endgenerate

    assign imm_out     = s_out.imm;
    assign imm_fmt     = s_out.fmt;
    assign imm_valid   = s_out.valid;
    assign imm_illegal = s_out.illegal;

endmodule
